bj_cmd_sequencer: RTL and testbench
===================================

// Module: bj_cmd_sequencer
// PURPOSE
//  Front end between the four raw player buttons and blackjack_core. It synchronises and optionally
//  debounces each button, and turns each press into a pending request. It then issues at most one
//  single-cycle command pulse at a time, and only while the core is not busy.
//  Before the first START it loads the core RNG once, using a free-running entropy counter.
// PARAMETERS
//  DB_CYCLES  16  consecutive stable synced samples needed to change a filtered level (BJ_DEBOUNCE_EN only)
//  CMD_GAP    4   idle cycles enforced after each issued command; legal range 1..255
//  SEED_W     16  width of the entropy counter and of rng_seed
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous, active-high reset
//  btn_hit_i    in   1       raw HIT button, asynchronous to clk
//  btn_stand_i  in   1       raw STAND button
//  btn_double_i in   1       raw DOUBLE button
//  btn_start_i  in   1       raw START button
//  core_busy    in   1       high while the core is dealing or settling; no command is issued while high
//  btn_hit      out  1       one-cycle HIT pulse to the core
//  btn_stand    out  1       one-cycle STAND pulse to the core
//  btn_double   out  1       one-cycle DOUBLE pulse to the core
//  btn_start    out  1       one-cycle START pulse to the core
//  rng_load     out  1       one-cycle seed-load strobe to the core
//  rng_seed     out  SEED_W  seed value; valid while rng_load is high
//  cmd_dropped  out  1       one-cycle pulse when a press is coalesced or discarded
//  last_cmd     out  3       code of the last issued command (bj_pkg CMD_*), 0 = none
// BEHAVIOUR
//  - Reset: every output is 0, all pending bits are clear, seed_loaded = 0, entropy = 0, FSM = IDLE.
//    Reset asserted mid-sequence aborts any pulse immediately; no partial pulse survives.
//  - Each input passes through a 2-FF synchroniser. A rising edge of the filtered level sets that
//    button's pending bit. An edge whose pending bit is already set asserts cmd_dropped and changes nothing else.
//  - Entropy counter: increments every cycle and wraps. A sampled value of 0 is replaced by 1
//    (the core LFSR must not be seeded with zero).
//  - FSM states: IDLE, SEED, ISSUE, GAP.
//    IDLE -> SEED  : a request exists, !core_busy, winner is START, seed_loaded == 0.
//    IDLE -> ISSUE : a request exists, !core_busy, and the SEED condition does not apply.
//    SEED          : rng_load = 1 and rng_seed = entropy for one cycle; seed_loaded <= 1; -> ISSUE.
//    ISSUE         : exactly one btn_* output high for one cycle; last_cmd updated; -> GAP.
//    GAP           : count CMD_GAP cycles, then -> IDLE.
//  - Arbitration priority: START > STAND > DOUBLE > HIT. The winner is latched on leaving IDLE and its
//    pending bit clears in that same cycle.
//  - Issuing START also clears the pending HIT, STAND and DOUBLE bits; each bit cleared this way
//    pulses cmd_dropped once (stale moves are not carried into a new round).
//  - While core_busy is high the FSM stays in IDLE and pending bits are retained.
//    core_busy rising during SEED, ISSUE or GAP does not abort the sequence in flight.
//  - A simultaneous edge and clear on the same pending bit resolves as set-wins (the new press is kept).
//  - Latency (idle, not busy, seed already loaded): the pulse appears 4 cycles after the raw input rises,
//    plus DB_CYCLES when BJ_DEBOUNCE_EN is defined. The first START adds 1 cycle for SEED.
// CONFIGURATION
//  BJ_DEBOUNCE_EN defined:
//    - A per-button counter requires DB_CYCLES consecutive equal synced samples before the filtered level changes.
//    - Any mismatching sample restarts the count.
//  BJ_DEBOUNCE_EN undefined:
//    - filtered level = synchronised level; no counter logic is generated.
//    - DB_CYCLES is ignored.
// STRUCTURE
//  - bj_pkg: CMD_NONE = 0, CMD_HIT = 1, CMD_STAND = 2, CMD_DOUBLE = 3, CMD_START = 4, plus FSM state localparams.
//  - Sub-module bj_btn_filter, instantiated 4x: synchroniser, optional debounce, rising-edge detect.
//    Outputs: level and rise.
//  - Top level holds the pending bits, arbiter, FSM, entropy counter and GAP counter.
// TESTING (undefined macro unless stated; CMD_GAP = 4)
//  1. Reset, then hold entropy = 0x00A5 and press START at cycle 10:
//     rng_load pulses with rng_seed = 0x00A5, then btn_start pulses 1 cycle later;
//     last_cmd = 4.
//  2. Press STAND and HIT in the same cycle, seed already loaded:
//     btn_stand pulses, 5 cycles later btn_hit pulses; last_cmd ends at 1.
//  3. core_busy held high 20 cycles, HIT pressed during it:
//     no pulse while busy; btn_hit pulses 1 cycle after busy falls.
//  4. HIT pending and busy, then START pressed:
//     btn_start issues; HIT pending cleared; cmd_dropped pulses once; no btn_hit follows.
//  5. BJ_DEBOUNCE_EN, DB_CYCLES = 16, input toggling every 5 cycles for 100 cycles:
//     no pulses. Then a 16-cycle stable high gives exactly one btn_hit pulse.
//  6. Assert rst during GAP after a START:
//     all outputs 0 next edge; seed_loaded cleared; the next START emits rng_load again.

Source files
------------

// File: rtl/bj_pkg.sv
// Command codes, sequencer FSM states and the shared arbitration helpers
// for the blackjack button front end.
package bj_pkg;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_HIT    = 3'd1,
        CMD_STAND  = 3'd2,
        CMD_DOUBLE = 3'd3,
        CMD_START  = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_GAP   = 2'd3
    } seq_state_e;

    // Bit positions inside every per-button vector (raw, rise, pending, pulse).
    localparam int N_BTN      = 4;
    localparam int BTN_HIT    = 0;
    localparam int BTN_STAND  = 1;
    localparam int BTN_DOUBLE = 2;
    localparam int BTN_START  = 3;

    function automatic cmd_e pick_winner(input logic [N_BTN-1:0] pend);
        cmd_e winner;
        winner = CMD_NONE;
        if (pend[BTN_START])       winner = CMD_START;
        else if (pend[BTN_STAND])  winner = CMD_STAND;
        else if (pend[BTN_DOUBLE]) winner = CMD_DOUBLE;
        else if (pend[BTN_HIT])    winner = CMD_HIT;
        return winner;
    endfunction

    function automatic logic [N_BTN-1:0] cmd_mask(input cmd_e cmd);
        logic [N_BTN-1:0] mask;
        mask = '0;
        case (cmd)
            CMD_HIT:    mask[BTN_HIT]    = 1'b1;
            CMD_STAND:  mask[BTN_STAND]  = 1'b1;
            CMD_DOUBLE: mask[BTN_DOUBLE] = 1'b1;
            CMD_START:  mask[BTN_START]  = 1'b1;
            default:    mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bj_btn_filter.sv
// One button lane: 2-FF synchroniser, optional debounce (BJ_DEBOUNCE_EN), rising-edge detect.
// Without BJ_DEBOUNCE_EN the filtered level is the synchronised level and DB_CYCLES is unused.
module bj_btn_filter #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    logic [1:0] r_sync;
    logic       r_level_d;
    logic       w_level;

    // NOTE: r_sync[0] may go metastable; only r_sync[1] is allowed to fan out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[0], i_btn};
    end

`ifdef BJ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [CNT_W-1:0] r_db_cnt;
    logic             r_level;

    // Counts consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else if (r_sync[1] == r_level) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == CNT_W'(DB_CYCLES - 1)) begin
            r_level  <= r_sync[1];
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_level_d <= 1'b0;
        else     r_level_d <= w_level;
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_level_d;

endmodule

// File: rtl/bj_cmd_sequencer.sv
// Turns four raw player buttons into one-at-a-time command pulses for blackjack_core and
// seeds the core RNG before the first START. BJ_DEBOUNCE_EN enables per-button debounce.
module bj_cmd_sequencer #(
    parameter int DB_CYCLES = 16,
    parameter int CMD_GAP   = 4,
    parameter int SEED_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_hit_i,
    input  logic              btn_stand_i,
    input  logic              btn_double_i,
    input  logic              btn_start_i,
    input  logic              core_busy,
    output logic              btn_hit,
    output logic              btn_stand,
    output logic              btn_double,
    output logic              btn_start,
    output logic              rng_load,
    output logic [SEED_W-1:0] rng_seed,
    output logic              cmd_dropped,
    output logic [2:0]        last_cmd
);
    import bj_pkg::*;

    if (CMD_GAP < 1 || CMD_GAP > 255) begin : g_bad_cmd_gap
        $error("bj_cmd_sequencer: CMD_GAP must lie in 1..255");
    end
    if (DB_CYCLES < 1) begin : g_bad_db_cycles
        $error("bj_cmd_sequencer: DB_CYCLES must be at least 1");
    end

    // The IDLE arbitration cycle is the last of the CMD_GAP quiet cycles between pulses.
    localparam int GAP_LEN = (CMD_GAP > 1) ? CMD_GAP - 1 : 1;

    logic [N_BTN-1:0]  w_raw;
    logic [N_BTN-1:0]  w_rise;
    logic [N_BTN-1:0]  w_level_unused;
    logic [N_BTN-1:0]  w_clr;
    logic [N_BTN-1:0]  w_stale;
    logic [N_BTN-1:0]  w_drop;
    logic              w_leave;
    cmd_e              w_winner;
    logic [4:0]        w_drop_total;
    logic [SEED_W-1:0] w_seed;

    logic [N_BTN-1:0]  r_pend;
    logic [3:0]        r_drop_debt;
    logic              r_cmd_dropped;
    logic [SEED_W-1:0] r_entropy;
    seq_state_e        r_state;
    cmd_e              r_win;
    cmd_e              r_last_cmd;
    logic              r_seed_loaded;
    logic [7:0]        r_gap_cnt;
    logic [N_BTN-1:0]  r_btn;
    logic              r_rng_load;
    logic [SEED_W-1:0] r_rng_seed;

    assign w_raw = {btn_start_i, btn_double_i, btn_stand_i, btn_hit_i};

    for (genvar g = 0; g < N_BTN; g++) begin : g_filter
        bj_btn_filter #(.DB_CYCLES(DB_CYCLES)) u_filter (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (w_raw[g]),
            .o_level(w_level_unused[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_winner = pick_winner(r_pend);
    assign w_leave  = (r_state == ST_IDLE) && (r_pend != '0) && !core_busy;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_clr   = '0;
        w_stale = '0;
        if (w_leave) begin
            w_clr = cmd_mask(w_winner);
            if (w_winner == CMD_START) w_stale = r_pend & ~cmd_mask(CMD_START);
        end
    end

    // Coalesced presses plus stale moves discarded by START; a same-cycle press always survives.
    assign w_drop       = (w_rise & r_pend & ~(w_clr | w_stale)) | w_stale;
    assign w_drop_total = 5'(r_drop_debt) + 5'($countones(w_drop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pend <= '0;
        else     r_pend <= (r_pend & ~(w_clr | w_stale)) | w_rise;
    end

    // Several drops in one cycle are paid out as one pulse per cycle from a small debt counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_debt   <= '0;
            r_cmd_dropped <= 1'b0;
        end else begin
            r_cmd_dropped <= (w_drop_total != 5'd0);
            if (w_drop_total == 5'd0)      r_drop_debt <= '0;
            else if (w_drop_total > 5'd16) r_drop_debt <= 4'd15;
            else                           r_drop_debt <= 4'(w_drop_total - 5'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_entropy <= '0;
        else     r_entropy <= r_entropy + 1'b1;
    end

    // The core LFSR locks up on an all-zero seed.
    assign w_seed = (r_entropy == '0) ? SEED_W'(1) : r_entropy;

    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_win         <= CMD_NONE;
            r_last_cmd    <= CMD_NONE;
            r_seed_loaded <= 1'b0;
            r_gap_cnt     <= '0;
            r_btn         <= '0;
            r_rng_load    <= 1'b0;
            r_rng_seed    <= '0;
        end else begin
            r_btn      <= '0;
            r_rng_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_leave) begin
                        r_win <= w_winner;
                        if (w_winner == CMD_START && !r_seed_loaded) begin
                            r_state    <= ST_SEED;
                            r_rng_load <= 1'b1;
                            r_rng_seed <= w_seed;
                        end else begin
                            r_state    <= ST_ISSUE;
                            r_btn      <= cmd_mask(w_winner);
                            r_last_cmd <= w_winner;
                        end
                    end
                end
                ST_SEED: begin
                    r_seed_loaded <= 1'b1;
                    r_state       <= ST_ISSUE;
                    r_btn         <= cmd_mask(r_win);
                    r_last_cmd    <= r_win;
                end
                ST_ISSUE: begin
                    r_state   <= ST_GAP;
                    r_gap_cnt <= '0;
                end
                ST_GAP: begin
                    if (r_gap_cnt == 8'(GAP_LEN - 1)) r_state <= ST_IDLE;
                    else                              r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign btn_hit     = r_btn[BTN_HIT];
    assign btn_stand   = r_btn[BTN_STAND];
    assign btn_double  = r_btn[BTN_DOUBLE];
    assign btn_start   = r_btn[BTN_START];
    assign rng_load    = r_rng_load;
    assign rng_seed    = r_rng_seed;
    assign cmd_dropped = r_cmd_dropped;
    assign last_cmd    = r_last_cmd;

endmodule

// File: tb/tb_bj_cmd_sequencer.sv
// Bench for bj_cmd_sequencer: directed scenarios plus randomized press/busy rounds checked
// against a transaction-level model (priority order, pulse spacing, drop counts, seed value).
module tb_bj_cmd_sequencer;

    localparam int CMD_GAP = 4;
    localparam int SPACING = CMD_GAP + 1;
`ifdef BJ_DEBOUNCE_EN
    localparam int DB   = 16;
    localparam int LAT  = 4 + DB;
    localparam int HOLD = DB + 4;
    localparam int REL  = DB + 4;
`else
    localparam int LAT  = 4;
    localparam int HOLD = 3;
    localparam int REL  = 3;
`endif
    localparam int EV_LOAD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  raw;
    logic        core_busy;
    logic        btn_hit, btn_stand, btn_double, btn_start;
    logic        rng_load, cmd_dropped;
    logic [15:0] rng_seed;
    logic [2:0]  last_cmd;

    bj_cmd_sequencer #(.DB_CYCLES(16), .CMD_GAP(CMD_GAP), .SEED_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_hit_i   (raw[0]),
        .btn_stand_i (raw[1]),
        .btn_double_i(raw[2]),
        .btn_start_i (raw[3]),
        .core_busy   (core_busy),
        .btn_hit     (btn_hit),
        .btn_stand   (btn_stand),
        .btn_double  (btn_double),
        .btn_start   (btn_start),
        .rng_load    (rng_load),
        .rng_seed    (rng_seed),
        .cmd_dropped (cmd_dropped),
        .last_cmd    (last_cmd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Clock edges since reset was released; the edge a pulse appears on is its timestamp.
    int unsigned edge_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        int          code;
        int unsigned at;
        logic [15:0] seed;
    } ev_t;

    ev_t evq[$];
    int  drop_pulses = 0;
    int  multi_hot   = 0;
    int  exp_q[$];
    int unsigned exp_first;

    function automatic ev_t mk_ev(input int code, input int unsigned at, input logic [15:0] seed);
        ev_t e;
        e.code = code;
        e.at   = at;
        e.seed = seed;
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if ($countones({btn_hit, btn_stand, btn_double, btn_start, rng_load}) > 1) multi_hot++;
            if (rng_load)    evq.push_back(mk_ev(EV_LOAD, edge_cnt, rng_seed));
            if (btn_hit)     evq.push_back(mk_ev(1, edge_cnt, 16'h0));
            if (btn_stand)   evq.push_back(mk_ev(2, edge_cnt, 16'h0));
            if (btn_double)  evq.push_back(mk_ev(3, edge_cnt, 16'h0));
            if (btn_start)   evq.push_back(mk_ev(4, edge_cnt, 16'h0));
            if (cmd_dropped) drop_pulses++;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m);
        raw = m;
        tick(HOLD);
        raw = '0;
        tick(REL);
    endtask

    task automatic wait_events(input int n, input int bound, input string tag);
        int waited;
        waited = 0;
        while (evq.size() < n && waited < bound) begin
            @(negedge clk);
            waited++;
        end
        if (evq.size() < n) check({tag, " timeout"}, evq.size(), n);
    endtask

    // Seed is the entropy count one edge before the load pulse, with zero mapped to one.
    function automatic logic [15:0] expect_seed(input int unsigned at);
        logic [15:0] s;
        s = 16'(at - 1);
        return (s == 16'h0) ? 16'h1 : s;
    endfunction

    // Model of one arbitration round: START wipes every move; otherwise STAND, DOUBLE, HIT.
    task automatic build_exp(input logic [3:0] pend, output int stale_drops);
        stale_drops = 0;
        if (pend[3]) begin
            exp_q.push_back(4);
            stale_drops = $countones(pend[2:0]);
        end else begin
            if (pend[1]) exp_q.push_back(2);
            if (pend[2]) exp_q.push_back(3);
            if (pend[0]) exp_q.push_back(1);
        end
    endtask

    task automatic expect_seq(input string tag, input int exp_drops, input int drops0);
        ev_t         ev;
        int unsigned at;
        wait_events(exp_q.size(), 80 + SPACING * exp_q.size(), tag);
        tick(SPACING + 4);
        at = exp_first;
        foreach (exp_q[i]) begin
            if (evq.size() == 0) break;
            ev = evq.pop_front();
            check({tag, " code"}, ev.code, exp_q[i]);
            check({tag, " cycle"}, ev.at, at);
            at += SPACING;
        end
        check({tag, " extra events"}, evq.size(), 0);
        check({tag, " dropped"}, drop_pulses - drops0, exp_drops);
        if (exp_q.size() > 0) check({tag, " last_cmd"}, last_cmd, exp_q[exp_q.size()-1]);
        exp_q.delete();
        evq.delete();
    endtask

    task automatic idle_case(input logic [3:0] m, input string tag);
        int drops0, stale;
        drops0    = drop_pulses;
        exp_first = edge_cnt + LAT;
        press(m);
        build_exp(m, stale);
        expect_seq(tag, stale, drops0);
    endtask

    task automatic busy_case(input logic [3:0] ma, input logic [3:0] mb, input int busy_len,
                             input string tag);
        int drops0, stale;
        drops0    = drop_pulses;
        core_busy = 1'b1;
        press(ma);
        press(mb);
        tick(busy_len);
        check({tag, " quiet while busy"}, evq.size(), 0);
        core_busy = 1'b0;
        exp_first = edge_cnt + 1;
        build_exp(ma | mb, stale);
        expect_seq(tag, stale + $countones(ma & mb), drops0);
    endtask

    task automatic first_start(input string tag, input logic check_a5);
        ev_t         ev;
        int unsigned e0;
        e0 = edge_cnt;
        press(4'b1000);
        wait_events(2, 80, tag);
        tick(SPACING + 4);
        if (evq.size() >= 2) begin
            ev = evq.pop_front();
            check({tag, " load code"}, ev.code, EV_LOAD);
            check({tag, " load cycle"}, ev.at, e0 + LAT);
            check({tag, " seed"}, ev.seed, expect_seed(ev.at));
            if (check_a5) check({tag, " seed a5"}, ev.seed, 16'h00A5);
            ev = evq.pop_front();
            check({tag, " start code"}, ev.code, 4);
            check({tag, " start cycle"}, ev.at, e0 + LAT + 1);
        end
        check({tag, " extra events"}, evq.size(), 0);
        check({tag, " last_cmd"}, last_cmd, 4);
        evq.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " btns"}, {btn_hit, btn_stand, btn_double, btn_start}, 0);
        check({tag, " rng_load"}, rng_load, 0);
        check({tag, " rng_seed"}, rng_seed, 0);
        check({tag, " cmd_dropped"}, cmd_dropped, 0);
        check({tag, " last_cmd"}, last_cmd, 0);
    endtask

    initial begin
        logic [3:0] ma, mb;
        int         kind;

        rst       = 1'b1;
        raw       = '0;
        core_busy = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;

        // First START: wait until the captured entropy will be 0x00A5.
        while (edge_cnt != 32'(16'hA5 - LAT + 1)) @(negedge clk);
        first_start("first start", 1'b1);

        idle_case(4'b0011, "stand+hit");
        busy_case(4'b0001, 4'b0000, 20, "hit under busy");
        busy_case(4'b0001, 4'b1000, 6, "start wipes hit");
        busy_case(4'b0001, 4'b0001, 4, "hit coalesced");

`ifdef BJ_DEBOUNCE_EN
        begin
            int drops0;
            drops0 = drop_pulses;
            for (int i = 0; i < 20; i++) begin
                raw[0] = ~raw[0];
                tick(5);
            end
            raw = '0;
            tick(DB + 4);
            check("bounce no events", evq.size(), 0);
            check("bounce no drops", drop_pulses - drops0, 0);
            exp_first = edge_cnt + LAT;
            exp_q.push_back(1);
            press(4'b0001);
            expect_seq("debounced hit", 0, drops0);
        end
`endif

        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 2);
            case (kind)
                0: idle_case(4'($urandom_range(1, 7)), "rand idle");
                1: idle_case(4'(8 | $urandom_range(0, 7)), "rand start");
                default: begin
                    ma = 4'($urandom_range(0, 15));
                    mb = 4'($urandom_range(0, 15));
                    if ((ma | mb) == 4'h0) mb = 4'b0100;
                    busy_case(ma, mb, $urandom_range(2, 20), "rand busy");
                end
            endcase
        end

        // Reset in GAP after a START must clear everything, including the seed-loaded flag.
        raw = 4'b1000;
        wait_events(1, 80, "start before reset");
        raw = '0;
        tick(2);
        rst = 1'b1;
        #1;
        check_all_zero("reset in gap");
        tick(2);
        rst = 1'b0;
        evq.delete();
        first_start("restart", 1'b0);

        check("one-hot pulses", multi_hot, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
